// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined immediate extender with output and skid registers
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    // Number of bits added above (or below, for UPPER) the raw immediate
    localparam int EXT_W = OUT_W - IN_W;

    localparam logic [1:0] MODE_SEXT  = 2'b00;
    localparam logic [1:0] MODE_ZEXT  = 2'b01;
    localparam logic [1:0] MODE_BOFF  = 2'b10;
    localparam logic [1:0] MODE_UPPER = 2'b11;

    // Output register (O)
    logic             o_valid;
    logic [OUT_W-1:0] o_data;
    logic [TAG_W-1:0] o_tag;

    // Skid register (S), only ever occupied while O is also occupied
    logic             s_valid;
    logic [OUT_W-1:0] s_data;
    logic [TAG_W-1:0] s_tag;

    // Extension results, formed once at the input
    logic [OUT_W-1:0] ext_sext;
    logic [OUT_W-1:0] ext_zext;
    logic [OUT_W-1:0] ext_data;

    logic accept;
    logic drain;
    logic o_free;

    // Select the extended operand for the requested mode
    always_comb begin
        ext_sext = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
        ext_zext = {{EXT_W{1'b0}}, in_imm};
        ext_data = ext_sext;
        case (in_mode)
            MODE_SEXT:  ext_data = ext_sext;
            MODE_ZEXT:  ext_data = ext_zext;
            MODE_BOFF:  ext_data = ext_sext << 2;
            MODE_UPPER: ext_data = {in_imm, {EXT_W{1'b0}}};
            default:    ext_data = ext_sext;
        endcase
    end

    // Handshake qualifiers; in_ready depends only on registered state
    always_comb begin
        in_ready = !s_valid;
        accept   = in_valid && in_ready && !rst;
        drain    = o_valid && out_ready;
        o_free   = !o_valid || drain;
    end

    // Two-entry FIFO update: O feeds the output, S absorbs one item of backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_tag   <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_tag   <= '0;
        end else if (o_free) begin
            if (s_valid) begin
                // Oldest item waits in S; it goes out next, no accept possible now
                o_valid <= 1'b1;
                o_data  <= s_data;
                o_tag   <= s_tag;
                s_valid <= 1'b0;
            end else if (accept) begin
                o_valid <= 1'b1;
                o_data  <= ext_data;
                o_tag   <= in_tag;
            end else begin
                // Data and tag hold their last value; only the valid bit clears
                o_valid <= 1'b0;
            end
        end else if (accept) begin
            // O is stalled; the single in-flight item parks in S
            s_valid <= 1'b1;
            s_data  <= ext_data;
            s_tag   <= in_tag;
        end
    end

    // Drive the output port from O
    always_comb begin
        out_valid = o_valid;
        out_data  = o_data;
        out_tag   = o_tag;
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - self-checking bench for imm_extend_pipe
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [11:0] b_in_imm;
    logic [1:0]  b_in_mode;
    logic [4:0]  b_in_tag;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [31:0] b_out_data;
    logic [4:0]  b_out_tag;

    int errors = 0;
    int checks = 0;

    bit mon_en = 1'b0;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
    } item_t;

    item_t exp_q[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(32), .TAG_W(5)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_imm    (b_in_imm),
        .in_mode   (b_in_mode),
        .in_tag    (b_in_tag),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_tag   (b_out_tag)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Extension computed arithmetically from the mode rules
    function automatic logic [63:0] model_ext(input logic [63:0] imm, input int mode,
                                              input int in_w, input int out_w);
        logic [63:0] out_mask;
        logic [63:0] in_mask;
        logic [63:0] base;
        logic [63:0] sext;
        logic [63:0] r;
        out_mask = (64'd1 << out_w) - 64'd1;
        in_mask  = (64'd1 << in_w) - 64'd1;
        base     = imm & in_mask;
        if (base[in_w-1])
            sext = (base | ~in_mask) & out_mask;
        else
            sext = base;
        case (mode)
            0:       r = sext;
            1:       r = base;
            2:       r = (sext * 64'd4) & out_mask;
            default: r = (base << (out_w - in_w)) & out_mask;
        endcase
        return r;
    endfunction

    // Scoreboard: the unit behaves as a 2-deep FIFO holding accepted-but-unsent items
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [4:0]  prev_tag;

    always @(negedge clk) begin
        if (mon_en) begin
            item_t it;
            chk("mon_out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            chk("mon_in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            if (out_valid && exp_q.size() > 0) begin
                chk("mon_out_data", 64'(out_data), 64'(exp_q[0].d));
                chk("mon_out_tag", 64'(out_tag), 64'(exp_q[0].t));
            end
            if (prev_stall && out_valid) begin
                chk("mon_stable_data", 64'(out_data), 64'(prev_data));
                chk("mon_stable_tag", 64'(out_tag), 64'(prev_tag));
            end
            if (rst) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_tag   = out_tag;
                if (out_valid && out_ready && exp_q.size() > 0)
                    void'(exp_q.pop_front());
                if (in_valid && in_ready) begin
                    it.d = 32'(model_ext(64'(in_imm), int'(in_mode), 16, 32));
                    it.t = in_tag;
                    exp_q.push_back(it);
                end
            end
        end
    end

    // Single item with out_ready high; result must appear one cycle later
    task automatic send1(input string name, input logic [15:0] imm, input logic [1:0] mode,
                         input logic [4:0] tag, input logic [31:0] exp);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_data"}, 64'(out_data), 64'(exp));
        chk({name, "_tag"}, 64'(out_tag), 64'(tag));
    endtask

    task automatic send_b(input string name, input logic [11:0] imm, input logic [1:0] mode,
                          input logic [31:0] exp);
        b_in_valid = 1'b1;
        b_in_imm   = imm;
        b_in_mode  = mode;
        b_in_tag   = 5'd2;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        chk({name, "_valid"}, 64'(b_out_valid), 64'd1);
        chk({name, "_data"}, 64'(b_out_data), 64'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int   idx;
        bit   acc;
        logic [4:0] rx[$];

        rst         = 1'b1;
        in_valid    = 1'b1;
        in_imm      = 16'h1234;
        in_mode     = 2'b00;
        in_tag      = 5'd31;
        out_ready   = 1'b1;
        b_in_valid  = 1'b0;
        b_in_imm    = '0;
        b_in_mode   = 2'b00;
        b_in_tag    = '0;
        b_out_ready = 1'b1;

        // Model pinned against hand-computed values
        chk("model_sext_neg", model_ext(64'h936E, 0, 16, 32), 64'hFFFF936E);
        chk("model_boff_neg", model_ext(64'h936E, 2, 16, 32), 64'hFFFE4DB8);
        chk("model_upper",    model_ext(64'h2D15, 3, 16, 32), 64'h2D150000);
        chk("model_w12_sext", model_ext(64'h800, 0, 12, 32), 64'hFFFFF800);

        // Reset with in_valid high: nothing may be accepted
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        mon_en = 1'b1;

        // Mode sweep
        send1("sext_neg",  16'h936E, 2'b00, 5'd1, 32'hFFFF936E);
        send1("zext_neg",  16'h936E, 2'b01, 5'd2, 32'h0000936E);
        send1("boff_neg",  16'h936E, 2'b10, 5'd3, 32'hFFFE4DB8);
        send1("upper_neg", 16'h936E, 2'b11, 5'd4, 32'h936E0000);
        send1("sext_pos",  16'h2D15, 2'b00, 5'd5, 32'h00002D15);
        send1("boff_pos",  16'h2D15, 2'b10, 5'd6, 32'h0000B454);
        send1("upper_pos", 16'h2D15, 2'b11, 5'd7, 32'h2D150000);
        @(posedge clk); #1;

        // Streaming 8 back-to-back items
        out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                in_valid = 1'b1;
                in_imm   = 16'h8421 ^ 16'(i * 16'h1357);
                in_mode  = i[1:0];
                in_tag   = i[4:0];
            end else begin
                in_valid = 1'b0;
            end
            chk("stream_in_ready", 64'(in_ready), 64'd1);
            if (i >= 1) begin
                chk("stream_valid", 64'(out_valid), 64'd1);
                chk("stream_tag", 64'(out_tag), 64'(i - 1));
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;

        // Backpressure: out_ready low for cycles 1..4
        idx = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            out_ready = !(cyc >= 1 && cyc <= 4);
            if (idx < 6) begin
                in_valid = 1'b1;
                in_imm   = 16'hF00D + 16'(idx);
                in_mode  = 2'(idx);
                in_tag   = 5'(idx);
            end else begin
                in_valid = 1'b0;
            end
            if (cyc >= 1 && cyc <= 4) begin
                chk("bp_stall_valid", 64'(out_valid), 64'd1);
                chk("bp_stall_tag", 64'(out_tag), 64'd0);
            end
            if (cyc >= 2 && cyc <= 5)
                chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            if (cyc == 6)
                chk("bp_in_ready_back", 64'(in_ready), 64'd1);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid && out_ready)
                rx.push_back(out_tag);
            @(posedge clk); #1;
            if (acc)
                idx++;
        end
        in_valid = 1'b0;
        chk("bp_count", 64'(rx.size()), 64'd6);
        for (int i = 0; i < rx.size(); i++)
            chk("bp_order", 64'(rx[i]), 64'(i));

        // Reset while O and S are both full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_imm    = 16'h0003;
        in_mode   = 2'b01;
        in_tag    = 5'd3;
        @(posedge clk); #1;
        in_imm = 16'h0004;
        in_tag = 5'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_tag", 64'(out_tag), 64'd3);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_imm   = 16'h0007;
        in_tag   = 5'd7;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", 64'(out_data), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        send1("after_rst", 16'h8001, 2'b00, 5'd9, 32'hFFFF8001);
        @(posedge clk); #1;
        chk("after_rst_drained", 64'(out_valid), 64'd0);

        // IN_W=12 variant
        send_b("w12_sext",  12'h800, 2'b00, 32'hFFFFF800);
        send_b("w12_zext",  12'h800, 2'b01, 32'h00000800);
        send_b("w12_upper", 12'h800, 2'b11, 32'h80000000);
        send_b("w12_boff",  12'h800, 2'b10, 32'(model_ext(64'h800, 2, 12, 32)));
        chk("w12_boff_lit", 64'(b_out_data), 64'hFFFFE000);

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension unit for the KGP-RISC datapath. It is the successor to the fixed 16→32 sign extender. It accepts an IN_W-bit immediate plus a 2-bit mode on a valid/ready interface and returns an OUT_W-bit operand one cycle later. A two-entry output stage (output register plus skid register) lets it sit between decode and execute without a combinational ready path.

## Interface
- IN_W, 16: width of the raw immediate. Legal range 1 ≤ IN_W ≤ OUT_W−2.
- OUT_W, 32: width of the extended operand.
- TAG_W, 5: width of the sideband tag carried with each item (e.g. destination register index).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream item valid.
- in_ready  output  1  unit can accept an item this cycle.
- in_imm  input  IN_W  raw immediate.
- in_mode  input  2  extension mode (see Operation).
- in_tag  input  TAG_W  sideband tag, passed through unchanged.
- out_valid  output  1  out_data/out_tag hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- out_data  output  OUT_W  extended operand.
- out_tag  output  TAG_W  tag of the item on out_data.

## Operation
- Modes, with s = in_imm[IN_W−1]:
  - 00 SEXT: {(OUT_W−IN_W){s}, in_imm}.
  - 01 ZEXT: {(OUT_W−IN_W){0}, in_imm}.
  - 10 BOFF: SEXT result shifted left by 2, zeros in bits [1:0]. Bits shifted out of the MSB are discarded.
  - 11 UPPER: in_imm << (OUT_W−IN_W), zeros below.
- Results are computed combinationally at the input and captured with the tag. Extension is never recomputed at the output.
- Storage: output register (O) and skid register (S), each with its own valid bit.
- in_ready = !S.valid. This is a registered signal, so there is no combinational path from out_ready to in_ready.
- Accept when in_valid && in_ready && !rst.
- Per-cycle update, with "drain" = out_valid && out_ready:
  - O free (!O.valid or drain) and S empty: the accepted item loads O. With no accept, O.valid clears on drain.
  - O free and S full: S moves to O and S clears. No accept is possible in this cycle because in_ready = 0.
  - O full and not draining: the accepted item loads S.
- Ordering is strictly FIFO. There is no drop and no duplication. out_data and out_tag stay stable while out_valid && !out_ready.
- No internal state other than O and S.

## Timing
- Reset, effective at the clock edge while rst = 1: O.valid = 0, S.valid = 0, out_data = 0, out_tag = 0, out_valid = 0. in_ready reads 1 from the first cycle after reset.
- in_valid is ignored in any cycle where rst = 1.
- Reset mid-operation discards the contents of O and S. No result is emitted for those items.
- Latency: an item accepted in cycle n appears on out_valid/out_data in cycle n+1 when O is free.
- Throughput: 1 item per cycle while out_ready = 1.
- Backpressure: after out_ready falls, at most one more item is accepted (into S). in_ready then drops in the next cycle.
- When out_ready returns, S reaches the output one cycle after O drains. in_ready rises in that same cycle.

## Test plan
- Mode sweep, IN_W=16, OUT_W=32, out_ready=1, in_imm=16'h936E:
  - mode 00 → 32'hFFFF936E
  - mode 01 → 32'h0000936E
  - mode 10 → 32'hFFFE4DB8
  - mode 11 → 32'h936E0000
  - Each result appears one cycle after acceptance.
- Positive input, in_imm=16'h2D15:
  - mode 00 → 32'h00002D15
  - mode 10 → 32'h0000B454
  - mode 11 → 32'h2D150000
- Streaming: 8 back-to-back items with tags 0..7, out_ready=1. Required: 8 outputs on 8 consecutive cycles, tags in order 0..7, in_ready constantly 1.
- Backpressure: stream with tags 0..5 and hold out_ready=0 for 4 cycles after the first output. Required:
  - out_data and out_tag stay stable on tag 0 while stalled.
  - in_ready falls after S fills (tag 1 held).
  - No item is lost; tags emerge 0..5 in order.
- Reset mid-stall: with O and S both full, assert rst for one cycle. Required:
  - Next cycle out_valid=0, out_data=0, in_ready=1.
  - A subsequent item with tag 9 emerges first.
- Parameter variant, IN_W=12, OUT_W=32, in_imm=12'h800:
  - mode 00 → 32'hFFFFF800
  - mode 01 → 32'h00000800
  - mode 11 → 32'h80000000
